// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
//   rx_state_t  - frame sequencer states
//   OVERSAMPLE  - oversample ticks per bit
//   MID_SAMPLE  - os_cnt value at mid start bit
//   LAST_SAMPLE - os_cnt value at mid data/stop bit
//   DATA_BITS   - data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;
  localparam int DATA_BITS   = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: line, control and byte-handshake signals of the UART
// receiver.
//   enable     - receiver enable (master -> slave)
//   rx         - raw UART line, idle high (master -> slave)
//   ready      - consumer accepts data_out (master -> slave)
//   data_out   - FIFO head byte (slave -> master)
//   valid      - FIFO non-empty (slave -> master)
//   frame_err  - one-cycle pulse on bad stop bit (slave -> master)
//   overrun    - one-cycle pulse on byte dropped, FIFO full (slave -> master)
//   fifo_count - current FIFO occupancy (slave -> master)
interface uart_rx_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             enable;
  logic             rx;
  logic             ready;
  logic [7:0]       data_out;
  logic             valid;
  logic             frame_err;
  logic             overrun;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output enable, rx, ready,
    input  data_out, valid, frame_err, overrun, fifo_count
  );

  modport slave (
    input  enable, rx, ready,
    output data_out, valid, frame_err, overrun, fifo_count
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
//   clk, rst - clock and synchronous active-high reset
//   push_i   - write data_i (ignored when full unless a pop occurs too)
//   data_i   - byte to write
//   pop_i    - remove head entry (ignored when empty)
//   data_o   - head entry (registered storage)
//   full_o   - FIFO holds DEPTH entries
//   empty_o  - FIFO holds no entries
//   count_o  - occupancy
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle: wr_ptr equals rd_ptr then, so the freed slot is reused.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Synchronizes rx, generates the 16x
// oversample tick, qualifies the start bit at mid-bit, shifts in 8 data bits
// LSB-first, checks the stop bit and queues good bytes in uart_rx_fifo.
//   clk - single clock, rising edge
//   rst - synchronous active-high reset
//   bus - uart_rx_ctrl_if slave: enable, rx, ready in; data_out, valid,
//         frame_err, overrun, fifo_count out
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_ctrl_if.slave    bus
);
  localparam int DIV_W = $clog2(BAUD_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx_meta_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  rx_state_t        state_q, state_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             push;
  logic             pop_req;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign tick = (div_q == DIV_W'(BAUD_DIV - 1));

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    if (tick) os_d = os_q + OS_W'(1);

    if (!bus.enable) begin
      // Disabled: abandon any partial frame silently.
      state_d = IDLE;
      os_d    = '0;
      bit_d   = '0;
      div_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          os_d  = '0;
          bit_d = '0;
          if (!rx_s_q) begin
            state_d = START;
            // Restarting the divider phase-aligns ticks to the start edge.
            div_d   = '0;
          end
        end
        START: begin
          if (tick && os_q == OS_W'(MID_SAMPLE)) begin
            os_d    = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick && os_q == OS_W'(LAST_SAMPLE)) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = STOP;
              os_d    = '0;
            end
          end
        end
        STOP: begin
          if (tick && os_q == OS_W'(LAST_SAMPLE)) begin
            state_d = IDLE;
            os_d    = '0;
            if (rx_s_q) push = 1'b1;
            else        frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A good byte is lost only if the FIFO is full and its head is not leaving.
  assign pop_req   = bus.ready && !fifo_empty;
  assign overrun_d = push && fifo_full && !pop_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      state_q     <= IDLE;
      os_q        <= '0;
      bit_q       <= '0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      div_q       <= div_d;
      state_q     <= state_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (bus.ready),
    .data_o  (bus.data_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.valid      = !fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with BAUD_DIV=4,
// FIFO_DEPTH=4 (64 clk per bit). Expected bytes are queued as frames are
// sent and compared as the consumer drains the FIFO.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 64;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(
    .BAUD_DIV   (4),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  logic [7:0] sb [$];

  // 10 ns clock
  always #5 clk = ~clk;

  // Count every cycle each flag is high; single-cycle pulses keep these
  // equal to the number of events.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cycles++;
    if (bus.overrun === 1'b1)   ov_cycles++;
  end

  // Hard stop in case anything stalls
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; the model queues a byte only when the FIFO has room.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      step(BIT_CLKS);
    end
    bus.rx = stop_bit;
    step(BIT_CLKS);
    bus.rx = 1'b1;
    if (stop_bit) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
  endtask

  // Start bit plus three data bits of 0xFF, leaving the FSM inside DATA.
  task automatic send_partial();
    bus.rx = 1'b0;
    step(BIT_CLKS);
    bus.rx = 1'b1;
    step(3 * BIT_CLKS);
  endtask

  task automatic check_flags(input string tag);
    @(negedge clk);
    n_checks++;
    if (fe_cycles !== exp_fe) begin
      n_fail++;
      $display("[TB] FAIL %s frame_err: got %0d cycles, expected %0d", tag, fe_cycles, exp_fe);
    end
    n_checks++;
    if (ov_cycles !== exp_ov) begin
      n_fail++;
      $display("[TB] FAIL %s overrun: got %0d cycles, expected %0d", tag, ov_cycles, exp_ov);
    end
  endtask

  task automatic check_count(input string tag);
    @(negedge clk);
    n_checks++;
    if (bus.fifo_count !== 3'(sb.size())) begin
      n_fail++;
      $display("[TB] FAIL %s fifo_count: got %0d, expected %0d", tag, bus.fifo_count, sb.size());
    end
    n_checks++;
    if (bus.valid !== (sb.size() != 0)) begin
      n_fail++;
      $display("[TB] FAIL %s valid: got %b, expected %b", tag, bus.valid, sb.size() != 0);
    end
  endtask

  // Pop every expected byte with a one-cycle ready pulse.
  task automatic drain(input string tag);
    logic [7:0] exp;
    while (sb.size() > 0) begin
      @(negedge clk);
      n_checks++;
      if (bus.valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL %s valid: got %b, expected 1", tag, bus.valid);
      end
      n_checks++;
      if (bus.fifo_count !== 3'(sb.size())) begin
        n_fail++;
        $display("[TB] FAIL %s fifo_count: got %0d, expected %0d", tag, bus.fifo_count, sb.size());
      end
      exp = sb.pop_front();
      n_checks++;
      if (bus.data_out !== exp) begin
        n_fail++;
        $display("[TB] FAIL %s data_out: got %02h, expected %02h", tag, bus.data_out, exp);
      end
      @(posedge clk);
      #1;
      bus.ready = 1'b1;
      step(1);
      bus.ready = 1'b0;
    end
    check_count({tag, "_empty"});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b0;
    bus.enable = 1'b1;
    bus.ready = 1'b0;
    step(6);
    @(negedge clk);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.data_out !== 8'h00 ||
        bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got valid=%b cnt=%0d data=%02h fe=%b ov=%b, expected 0 0 00 0 0",
               bus.valid, bus.fifo_count, bus.data_out, bus.frame_err, bus.overrun);
    end
    bus.rx = 1'b1;
    step(2);
    rst = 1'b0;
    fe_cycles = 0;
    ov_cycles = 0;
    step(100);
    check_count("reset_idle");
    check_flags("reset_idle");
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1);
    step(4);
    check_count("single_hold");
    drain("single");
    check_flags("single");
  endtask

  task automatic test_glitch();
    bus.rx = 1'b0;
    step(16);
    bus.rx = 1'b1;
    step(2 * BIT_CLKS);
    check_count("glitch");
    check_flags("glitch");
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    check_count("frame_err");
    check_flags("frame_err");
    send_frame(8'h5A, 1'b1);
    drain("after_ferr");
    check_flags("after_ferr");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check_count("overrun_full");
    check_flags("overrun");
    drain("overrun");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    check_count("b2b");
    drain("b2b");
    check_flags("b2b");
  endtask

  task automatic test_disrupt_rst();
    send_frame(8'h77, 1'b1);
    send_partial();
    rst = 1'b1;
    step(4);
    rst = 1'b0;
    sb.delete();
    step(20);
    check_count("rst_mid");
    check_flags("rst_mid");
    send_frame(8'h81, 1'b1);
    drain("rst_next");
  endtask

  task automatic test_disrupt_enable();
    send_frame(8'h42, 1'b1);
    send_partial();
    bus.enable = 1'b0;
    step(10);
    bus.enable = 1'b1;
    step(2 * BIT_CLKS);
    check_count("en_mid");
    check_flags("en_mid");
    send_frame(8'h81, 1'b1);
    drain("en_next");
    check_flags("en_next");
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_disrupt_rst();
    test_disrupt_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
